// File: rtl/song_reader.sv
// song_reader: walks note/duration words of the selected song out of a
// synchronous ROM. Each note goes to the note player with a one-cycle
// new_note pulse. song_done pulses at an end marker (duration 0) or after
// the last note slot.
module song_reader #(
    parameter int NUM_SONGS = 4,
    parameter int SONG_W    = 2,
    parameter int ADDR_W    = 5,
    parameter int NOTE_W    = 6,
    parameter int DUR_W     = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     play,
    input  logic                     reset_play,
    input  logic                     NextSong,
    input  logic                     note_done,
    output logic [SONG_W+ADDR_W-1:0] rom_addr,
    input  logic [NOTE_W+DUR_W-1:0]  rom_data,
    output logic [NOTE_W-1:0]        note,
    output logic [DUR_W-1:0]         duration,
    output logic                     new_note,
    output logic                     song_done,
    output logic [SONG_W-1:0]        current_song
);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, WAIT_NOTE, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);

    state_t              state, state_n;
    logic [SONG_W-1:0]   song, song_n;
    logic [ADDR_W-1:0]   note_addr, addr_n;
    logic [SONG_W+ADDR_W-1:0] rom_addr_n;
    logic [NOTE_W-1:0]   note_n;
    logic [DUR_W-1:0]    dur_n;
    logic                new_note_n, song_done_n;
    logic [NOTE_W-1:0]   rom_note;
    logic [DUR_W-1:0]    rom_dur;

    assign {rom_note, rom_dur} = rom_data;
    assign current_song = song;

    // Next-state and next-output logic; commands override the FSM and
    // suppress any pulse that would have been produced this cycle.
    always_comb begin
        state_n     = state;
        song_n      = song;
        addr_n      = note_addr;
        rom_addr_n  = rom_addr;
        note_n      = note;
        dur_n       = duration;
        new_note_n  = 1'b0;
        song_done_n = 1'b0;
        if (NextSong) begin
            // Also covers NextSong together with reset_play.
            song_n     = (song == LAST_SONG) ? '0 : song + SONG_W'(1);
            addr_n     = '0;
            note_n     = '0;
            dur_n      = '0;
            state_n    = IDLE;
            rom_addr_n = {song_n, {ADDR_W{1'b0}}};
        end else if (reset_play) begin
            addr_n     = '0;
            note_n     = '0;
            dur_n      = '0;
            state_n    = IDLE;
            rom_addr_n = {song, {ADDR_W{1'b0}}};
        end else begin
            case (state)
                IDLE: begin
                    if (play) begin
                        state_n    = FETCH;
                        rom_addr_n = {song, note_addr};
                    end
                end
                // ROM registers rom_addr this cycle; data is seen in DECODE.
                FETCH: state_n = DECODE;
                DECODE: begin
                    if (rom_dur == '0) begin
                        state_n = DONE;
                    end else begin
                        note_n     = rom_note;
                        dur_n      = rom_dur;
                        new_note_n = 1'b1;
                        state_n    = WAIT_NOTE;
                    end
                end
                WAIT_NOTE: begin
                    // note_done only counts while playing.
                    if (play && note_done) begin
                        if (note_addr == LAST_ADDR) begin
                            state_n = DONE;
                        end else begin
                            addr_n     = note_addr + ADDR_W'(1);
                            rom_addr_n = {song, addr_n};
                            state_n    = FETCH;
                        end
                    end
                end
                DONE: begin
                    song_done_n = 1'b1;
                    addr_n      = '0;
                    note_n      = '0;
                    dur_n       = '0;
                    state_n     = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            song      <= '0;
            note_addr <= '0;
            rom_addr  <= '0;
            note      <= '0;
            duration  <= '0;
            new_note  <= 1'b0;
            song_done <= 1'b0;
        end else begin
            state     <= state_n;
            song      <= song_n;
            note_addr <= addr_n;
            rom_addr  <= rom_addr_n;
            note      <= note_n;
            duration  <= dur_n;
            new_note  <= new_note_n;
            song_done <= song_done_n;
        end
    end

endmodule
